// File: rtl/pass_sequencer.sv
// pass_sequencer: tiles a conv layer into (row, out-chan, in-chan-group) passes
// and launches one NoC pass per tile, waiting for its completion pulse.
module pass_sequencer #(
  parameter int m_WIDTH  = 8,
  parameter int E_WIDTH  = 6,
  parameter int C_WIDTH  = 10,
  parameter int PC_WIDTH = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [m_WIDTH-1:0]  M,
  input  logic [m_WIDTH-1:0]  m,
  input  logic [E_WIDTH-1:0]  E,
  input  logic [E_WIDTH-1:0]  e,
  input  logic [C_WIDTH-1:0]  C,
  input  logic [C_WIDTH-1:0]  c,
  input  logic                noc_done,
  output logic                noc_start,
  output logic [m_WIDTH-1:0]  psum_channel_base,
  output logic [E_WIDTH-1:0]  psum_row_base,
  output logic [C_WIDTH-1:0]  ifmap_chan_base,
  output logic [m_WIDTH-1:0]  m_eff,
  output logic [E_WIDTH-1:0]  e_eff,
  output logic [C_WIDTH-1:0]  c_eff,
  output logic                first_acc,
  output logic                last_acc,
  output logic [PC_WIDTH-1:0] pass_count,
  output logic                busy,
  output logic                done,
  output logic                cfg_error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_ADV,
    S_FIN
  } state_t;

  state_t state_q, state_d;

  logic [m_WIDTH-1:0]  m_tot_q, m_pp_q;
  logic [E_WIDTH-1:0]  e_tot_q, e_pp_q;
  logic [C_WIDTH-1:0]  c_tot_q, c_pp_q;

  logic [m_WIDTH-1:0]  oc_q, oc_d;
  logic [E_WIDTH-1:0]  row_q, row_d;
  logic [C_WIDTH-1:0]  ch_q, ch_d;
  logic [m_WIDTH-1:0]  meff_q, meff_d;
  logic [E_WIDTH-1:0]  eeff_q, eeff_d;
  logic [C_WIDTH-1:0]  ceff_q, ceff_d;
  logic                first_q, first_d;
  logic                last_q, last_d;
  logic [PC_WIDTH-1:0] pc_q;
  logic                err_q;

  logic load_cfg, tile_ld, pc_inc, pc_clr;
  logic set_err, clr_err;
  logic zero_cfg;

  logic [m_WIDTH-1:0] mt, mp, m_rem;
  logic [E_WIDTH-1:0] et, ep, e_rem;
  logic [C_WIDTH-1:0] ct, cp, c_rem;

  // Sums carry one extra bit so base+step never wraps.
  logic [m_WIDTH:0] oc_sum;
  logic [E_WIDTH:0] row_sum;
  logic [C_WIDTH:0] ch_sum, last_sum;
  logic             ch_wrap, oc_wrap, row_wrap;

  assign zero_cfg = (M == '0) || (m == '0) || (E == '0) ||
                    (e == '0) || (C == '0) || (c == '0);

  assign oc_sum  = {1'b0, oc_q}  + {1'b0, m_pp_q};
  assign row_sum = {1'b0, row_q} + {1'b0, e_pp_q};
  assign ch_sum  = {1'b0, ch_q}  + {1'b0, c_pp_q};

  assign ch_wrap  = ch_sum  >= {1'b0, c_tot_q};
  assign oc_wrap  = oc_sum  >= {1'b0, m_tot_q};
  assign row_wrap = row_sum >= {1'b0, e_tot_q};

  always_comb begin
    state_d  = state_q;
    load_cfg = 1'b0;
    tile_ld  = 1'b0;
    pc_inc   = 1'b0;
    pc_clr   = 1'b0;
    set_err  = 1'b0;
    clr_err  = 1'b0;
    oc_d     = oc_q;
    row_d    = row_q;
    ch_d     = ch_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          load_cfg = 1'b1;
          pc_clr   = 1'b1;
          if (zero_cfg) begin
            set_err = 1'b1;
            state_d = S_FIN;
          end else begin
            clr_err = 1'b1;
            tile_ld = 1'b1;
            oc_d    = '0;
            row_d   = '0;
            ch_d    = '0;
            state_d = S_LAUNCH;
          end
        end
      end
      S_LAUNCH: state_d = S_WAIT;
      S_WAIT: begin
        if (noc_done) begin
          pc_inc  = 1'b1;
          state_d = S_ADV;
        end
      end
      S_ADV: begin
        if (ch_wrap && oc_wrap && row_wrap) begin
          state_d = S_FIN;
        end else begin
          tile_ld = 1'b1;
          state_d = S_LAUNCH;
          if (!ch_wrap) begin
            ch_d = ch_sum[C_WIDTH-1:0];
          end else begin
            ch_d = '0;
            if (!oc_wrap) begin
              oc_d = oc_sum[m_WIDTH-1:0];
            end else begin
              oc_d  = '0;
              row_d = row_sum[E_WIDTH-1:0];
            end
          end
        end
      end
      S_FIN: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Tile sizes clip against the remainder of the layer.
  always_comb begin
    mt = load_cfg ? M : m_tot_q;
    mp = load_cfg ? m : m_pp_q;
    et = load_cfg ? E : e_tot_q;
    ep = load_cfg ? e : e_pp_q;
    ct = load_cfg ? C : c_tot_q;
    cp = load_cfg ? c : c_pp_q;
    m_rem    = mt - oc_d;
    e_rem    = et - row_d;
    c_rem    = ct - ch_d;
    meff_d   = (mp < m_rem) ? mp : m_rem;
    eeff_d   = (ep < e_rem) ? ep : e_rem;
    ceff_d   = (cp < c_rem) ? cp : c_rem;
    last_sum = {1'b0, ch_d} + {1'b0, cp};
    first_d  = (ch_d == '0);
    last_d   = last_sum >= {1'b0, ct};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      m_tot_q <= '0;
      m_pp_q  <= '0;
      e_tot_q <= '0;
      e_pp_q  <= '0;
      c_tot_q <= '0;
      c_pp_q  <= '0;
      oc_q    <= '0;
      row_q   <= '0;
      ch_q    <= '0;
      meff_q  <= '0;
      eeff_q  <= '0;
      ceff_q  <= '0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      pc_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load_cfg) begin
        m_tot_q <= M;
        m_pp_q  <= m;
        e_tot_q <= E;
        e_pp_q  <= e;
        c_tot_q <= C;
        c_pp_q  <= c;
      end
      if (tile_ld) begin
        oc_q    <= oc_d;
        row_q   <= row_d;
        ch_q    <= ch_d;
        meff_q  <= meff_d;
        eeff_q  <= eeff_d;
        ceff_q  <= ceff_d;
        first_q <= first_d;
        last_q  <= last_d;
      end
      if (pc_clr) begin
        pc_q <= '0;
      end else if (pc_inc) begin
        pc_q <= pc_q + 1'b1;
      end
      if (set_err) begin
        err_q <= 1'b1;
      end else if (clr_err) begin
        err_q <= 1'b0;
      end
    end
  end

  assign noc_start         = (state_q == S_LAUNCH);
  assign busy              = (state_q == S_LAUNCH) || (state_q == S_WAIT) ||
                             (state_q == S_ADV);
  assign done              = (state_q == S_FIN);
  assign psum_channel_base = oc_q;
  assign psum_row_base     = row_q;
  assign ifmap_chan_base   = ch_q;
  assign m_eff             = meff_q;
  assign e_eff             = eeff_q;
  assign c_eff             = ceff_q;
  assign first_acc         = first_q;
  assign last_acc          = last_q;
  assign pass_count        = pc_q;
  assign cfg_error         = err_q;

endmodule

// File: tb/tb_pass_sequencer.sv
// Directed bench for pass_sequencer: per-pass expectation tables plus
// hand-written sequences for error, reset and ignored-event corners.
module tb_pass_sequencer;

  logic        clk = 1'b0;
  logic        reset, start, noc_done;
  logic [7:0]  M, m;
  logic [5:0]  E, e;
  logic [9:0]  C, c;
  logic        noc_start, first_acc, last_acc, busy, done, cfg_error;
  logic [7:0]  psum_channel_base, m_eff;
  logic [5:0]  psum_row_base, e_eff;
  logic [9:0]  ifmap_chan_base, c_eff;
  logic [15:0] pass_count;

  int nerr = 0;
  int nchk = 0;

  typedef struct {
    int row, oc, ch, me, ee, ce;
    bit fa, la;
  } pass_t;

  pass_t t1[8];
  pass_t t2[3];
  pass_t expq[$];

  always #5 clk = ~clk;

  pass_sequencer dut (
    .clk(clk), .reset(reset), .start(start),
    .M(M), .m(m), .E(E), .e(e), .C(C), .c(c),
    .noc_done(noc_done), .noc_start(noc_start),
    .psum_channel_base(psum_channel_base),
    .psum_row_base(psum_row_base),
    .ifmap_chan_base(ifmap_chan_base),
    .m_eff(m_eff), .e_eff(e_eff), .c_eff(c_eff),
    .first_acc(first_acc), .last_acc(last_acc),
    .pass_count(pass_count), .busy(busy), .done(done),
    .cfg_error(cfg_error)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_idle_zero();
    chk("rst_noc_start", noc_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cfg_error", cfg_error, 0);
    chk("rst_pass_count", pass_count, 0);
    chk("rst_oc_base", psum_channel_base, 0);
    chk("rst_row_base", psum_row_base, 0);
    chk("rst_ch_base", ifmap_chan_base, 0);
    chk("rst_m_eff", m_eff, 0);
    chk("rst_e_eff", e_eff, 0);
    chk("rst_c_eff", c_eff, 0);
    chk("rst_first", first_acc, 0);
    chk("rst_last", last_acc, 0);
  endtask

  // Runs the passes in expq. noise injects ignored start/noc_done pulses
  // and changes the config inputs mid-layer; abort_at resets in WAIT.
  task automatic run_layer(input int mt, mp, et, ep, ct, cp,
                           input bit noise, input int abort_at);
    int n;
    M = 8'(mt); m = 8'(mp); E = 6'(et); e = 6'(ep);
    C = 10'(ct); c = 10'(cp);
    start = 1'b1;
    for (int i = 0; i < expq.size(); i++) begin
      n = 0;
      do begin
        @(negedge clk);
        start = 1'b0;
        n++;
      end while (!noc_start && n < 40);
      if (!noc_start) begin
        chk("launch_timeout", 0, 1);
        return;
      end
      chk("launch_latency", n, 1);
      chk("row_base", psum_row_base, expq[i].row);
      chk("oc_base", psum_channel_base, expq[i].oc);
      chk("ch_base", ifmap_chan_base, expq[i].ch);
      chk("m_eff", m_eff, expq[i].me);
      chk("e_eff", e_eff, expq[i].ee);
      chk("c_eff", c_eff, expq[i].ce);
      chk("first_acc", first_acc, expq[i].fa);
      chk("last_acc", last_acc, expq[i].la);
      chk("busy_launch", busy, 1);
      chk("cfg_error_launch", cfg_error, 0);
      chk("pass_count_run", pass_count, i);
      if (noise) begin
        noc_done = 1'b1;
        if (i == 0) begin
          M = 8'd3; m = 8'd0; E = 6'd2; e = 6'd1;
          C = 10'd7; c = 10'd2;
        end
      end
      @(negedge clk);
      noc_done = 1'b0;
      chk("noc_start_pulse", noc_start, 0);
      chk("row_base_wait", psum_row_base, expq[i].row);
      chk("oc_base_wait", psum_channel_base, expq[i].oc);
      if (i == abort_at) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        return;
      end
      if (noise) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_in_wait", noc_start, 0);
      end
      @(negedge clk);
      noc_done = 1'b1;
      @(negedge clk);
      noc_done = 1'b0;
      chk("adv_no_start", noc_start, 0);
    end
    @(negedge clk);
    chk("done_pulse", done, 1);
    chk("busy_finish", busy, 0);
    chk("pass_total", pass_count, expq.size());
    chk("cfg_error_end", cfg_error, 0);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("noc_start_idle", noc_start, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // (row, oc, ch, m_eff, e_eff, c_eff, first, last)
    t1[0] = '{0, 0, 0, 4, 3, 1, 1, 0};
    t1[1] = '{0, 0, 1, 4, 3, 1, 0, 1};
    t1[2] = '{0, 4, 0, 4, 3, 1, 1, 0};
    t1[3] = '{0, 4, 1, 4, 3, 1, 0, 1};
    t1[4] = '{3, 0, 0, 4, 3, 1, 1, 0};
    t1[5] = '{3, 0, 1, 4, 3, 1, 0, 1};
    t1[6] = '{3, 4, 0, 4, 3, 1, 1, 0};
    t1[7] = '{3, 4, 1, 4, 3, 1, 0, 1};
    t2[0] = '{0, 0, 0, 4, 5, 3, 1, 1};
    t2[1] = '{0, 4, 0, 4, 5, 3, 1, 1};
    t2[2] = '{0, 8, 0, 2, 5, 3, 1, 1};

    reset = 1'b1; start = 1'b0; noc_done = 1'b0;
    M = '0; m = '0; E = '0; e = '0; C = '0; c = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk_idle_zero();

    noc_done = 1'b1;
    @(negedge clk);
    noc_done = 1'b0;
    @(negedge clk);
    chk("done_in_idle", noc_start, 0);

    expq.delete();
    foreach (t1[i]) expq.push_back(t1[i]);
    run_layer(8, 4, 6, 3, 2, 1, 1'b1, -1);

    M = 8'd10; m = 8'd0; E = 6'd5; e = 6'd5; C = 10'd3; c = 10'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("err_done", done, 1);
    chk("err_flag", cfg_error, 1);
    chk("err_no_launch", noc_start, 0);
    @(negedge clk);
    chk("err_done_clear", done, 0);
    chk("err_sticky", cfg_error, 1);
    chk("err_idle_launch", noc_start, 0);

    expq.delete();
    foreach (t2[i]) expq.push_back(t2[i]);
    run_layer(10, 4, 5, 5, 3, 3, 1'b0, -1);

    expq.delete();
    foreach (t1[i]) expq.push_back(t1[i]);
    run_layer(8, 4, 6, 3, 2, 1, 1'b0, 2);
    chk_idle_zero();
    noc_done = 1'b1;
    @(negedge clk);
    noc_done = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("post_rst_no_start", noc_start, 0);
    end
    run_layer(8, 4, 6, 3, 2, 1, 1'b0, -1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
